// File: rtl/fifo_ctrl_async_fft.sv
// Dual-clock FIFO controller for the FFT sample FIFO: binary/gray pointers, gray-code
// crossing, pessimistic full/empty flags, water levels and error pulses around an external SDPRAM.
`timescale 1ns/1ps
module fifo_ctrl_async_fft #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  wr_clk,
    input  logic                  asyn_rst,
    input  logic                  rd_clk,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic                  wr_err,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_water_level,
    output logic                  rd_err,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ---------------- write domain ----------------
    logic [PW-1:0] wr_ptr, wr_gray, rd_gray_meta, rd_gray_sync;
    logic [PW-1:0] wr_ptr_next, wr_gray_next, wr_level_next;
    logic          push;

    assign push          = wr_en & ~full;
    assign wr_ptr_next   = wr_ptr + PW'(push);
    assign wr_gray_next  = bin2gray(wr_ptr_next);
    assign wr_level_next = wr_ptr_next - gray2bin(rd_gray_sync);

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = wr_data;

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wr_ptr         <= '0;
            wr_gray        <= '0;
            rd_gray_meta   <= '0;
            rd_gray_sync   <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            wr_water_level <= '0;
            wr_err         <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_next;
            wr_gray        <= wr_gray_next;
            rd_gray_meta   <= rd_gray;
            rd_gray_sync   <= rd_gray_meta;
            // Full when the write pointer is one lap ahead: top two gray bits inverted.
            full           <= (wr_gray_next == {~rd_gray_sync[PW-1:PW-2], rd_gray_sync[PW-3:0]});
            almost_full    <= (wr_level_next >= AF_TH);
            wr_water_level <= wr_level_next;
            wr_err         <= wr_en & full;
        end
    end

    // ---------------- read domain ----------------
    logic          rd_rst_meta, rd_rst;
    logic [PW-1:0] rd_ptr, rd_gray, wr_gray_meta, wr_gray_sync;
    logic [PW-1:0] rd_ptr_next, rd_gray_next, rd_level_next;
    logic          pop;

    // Reset asserts immediately but releases aligned to rd_clk.
    always_ff @(posedge rd_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            rd_rst_meta <= 1'b1;
            rd_rst      <= 1'b1;
        end else begin
            rd_rst_meta <= 1'b0;
            rd_rst      <= rd_rst_meta;
        end
    end

    assign pop           = rd_en & ~empty;
    assign rd_ptr_next   = rd_ptr + PW'(pop);
    assign rd_gray_next  = bin2gray(rd_ptr_next);
    assign rd_level_next = gray2bin(wr_gray_sync) - rd_ptr_next;

    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign rd_data     = ram_rd_data;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr         <= '0;
            rd_gray        <= '0;
            wr_gray_meta   <= '0;
            wr_gray_sync   <= '0;
            empty          <= 1'b1;
            almost_empty   <= 1'b1;
            rd_water_level <= '0;
            rd_err         <= 1'b0;
        end else begin
            rd_ptr         <= rd_ptr_next;
            rd_gray        <= rd_gray_next;
            wr_gray_meta   <= wr_gray;
            wr_gray_sync   <= wr_gray_meta;
            empty          <= (rd_gray_next == wr_gray_sync);
            almost_empty   <= (rd_level_next <= AE_TH);
            rd_water_level <= rd_level_next;
            rd_err         <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_async_fft.sv
// Bench for fifo_ctrl_async_fft: directed fill/drain/reset scenarios plus a randomized
// dual-clock stream, all checked against a queue model of FIFO contents and addresses.
`timescale 1ns/1ps
module tb_fifo_ctrl_async_fft;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          asyn_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, almost_full, wr_err, empty, almost_empty, rd_err;
    logic [AW:0]   wr_water_level, rd_water_level;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;

    fifo_ctrl_async_fft #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)
    ) dut (
        .wr_clk(wr_clk), .asyn_rst(asyn_rst), .rd_clk(rd_clk),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .full(full), .almost_full(almost_full), .wr_water_level(wr_water_level), .wr_err(wr_err),
        .empty(empty), .almost_empty(almost_empty), .rd_water_level(rd_water_level), .rd_err(rd_err),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // clock / reset: 100 MHz write, ~73 MHz read
    always #5 wr_clk = ~wr_clk;
    always #6.849 rd_clk = ~rd_clk;

    // SDPRAM with combinational read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge wr_clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_addr];

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic wr_sync();
        @(posedge wr_clk); #1;
    endtask

    task automatic rd_sync();
        @(posedge rd_clk); #1;
    endtask

    // One write-clock cycle; called 1ns after a wr_clk edge.
    task automatic wr_cycle(input logic en, input logic [DW-1:0] d);
        logic was_full, acc;
        wr_en = en;
        wr_data = d;
        was_full = full;
        #1;
        acc = en && !was_full;
        check("ram_wr_en", ram_wr_en, acc);
        if (acc) begin
            check("ram_wr_addr", ram_wr_addr, wr_cnt % DEPTH);
            check("ram_wr_data", ram_wr_data, d);
            exp_q.push_back(d);
            wr_cnt++;
        end
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        check("wr_err", wr_err, en && was_full);
        check("almost_full_rule", almost_full, wr_water_level >= 12);
        check("wr_level_not_low", wr_water_level >= exp_q.size(), 1);
        if (exp_q.size() == DEPTH) check("full_pessimistic", full, 1);
    endtask

    // One read-clock cycle; called 1ns after an rd_clk edge.
    task automatic rd_cycle(input logic en);
        logic was_empty, acc;
        rd_en = en;
        was_empty = empty;
        #1;
        acc = en && !was_empty;
        check("ram_rd_addr", ram_rd_addr, rd_cnt % DEPTH);
        if (acc) begin
            if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
            else check("model_has_data", exp_q.size(), 1);
            rd_cnt++;
        end
        @(posedge rd_clk); #1;
        rd_en = 1'b0;
        check("rd_err", rd_err, en && was_empty);
        check("almost_empty_rule", almost_empty, rd_water_level <= 2);
        check("rd_level_not_high", rd_water_level <= exp_q.size(), 1);
        if (exp_q.size() == 0) check("empty_pessimistic", empty, 1);
    endtask

    task automatic apply_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        asyn_rst = 1'b1;
        repeat (2) wr_sync();
        check("rst_empty_async", empty, 1);
        check("rst_full_async", full, 0);
        asyn_rst = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (4) rd_sync();
        wr_sync();
    endtask

    task automatic wait_not_empty(input int max_cycles, output int n);
        n = 0;
        while (empty && n < max_cycles) begin
            rd_sync();
            n++;
        end
        check("empty_release_timeout", empty, 0);
    endtask

    int n;
    int pushed, popped;

    initial begin
        // 1: idle after reset
        apply_reset();
        check("idle_empty", empty, 1);
        check("idle_full", full, 0);
        check("idle_almost_empty", almost_empty, 1);
        check("idle_almost_full", almost_full, 0);
        check("idle_wr_level", wr_water_level, 0);
        check("idle_rd_level", rd_water_level, 0);
        check("idle_ram_wr_en", ram_wr_en, 0);
        check("idle_rd_err", rd_err, 0);
        check("idle_wr_err", wr_err, 0);

        // 2: fill 16 words, then one rejected push
        for (int i = 0; i < DEPTH; i++) begin
            wr_cycle(1'b1, DW'(i + 1));
            check("fill_level", wr_water_level, i + 1);
            check("fill_full", full, i == DEPTH - 1);
            check("fill_almost_full", almost_full, i + 1 >= 12);
        end
        wr_cycle(1'b1, 16'h0011);
        check("overflow_wr_err", wr_err, 1);
        check("overflow_ram0", mem[0], 16'h0001);
        check("overflow_level", wr_water_level, DEPTH);
        wr_cycle(1'b0, '0);
        check("wr_err_one_cycle", wr_err, 0);

        // 3: drain 16 words, then one rejected pop
        rd_sync();
        wait_not_empty(10, n);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_head", rd_data, i + 1);
            rd_cycle(1'b1);
            check("drain_empty", empty, i == DEPTH - 1);
        end
        rd_cycle(1'b1);
        check("underflow_rd_err", rd_err, 1);
        check("underflow_ptr_held", ram_rd_addr, 0);
        rd_cycle(1'b0);
        check("rd_err_one_cycle", rd_err, 0);

        // 4: randomized concurrent stream of 100 words
        wr_sync();
        pushed = 0;
        popped = 0;
        fork
            begin
                for (int c = 0; c < 4000 && pushed < 100; c++) begin
                    if (!full && $urandom_range(0, 3) != 0) begin
                        wr_cycle(1'b1, DW'($urandom));
                        pushed++;
                    end else begin
                        wr_cycle(1'b0, '0);
                    end
                end
            end
            begin
                rd_sync();
                for (int c = 0; c < 4000 && popped < 100; c++) begin
                    if (!empty && $urandom_range(0, 2) != 0) begin
                        rd_cycle(1'b1);
                        popped++;
                    end else begin
                        rd_cycle(1'b0);
                    end
                end
            end
        join
        check("stream_pushed", pushed, 100);
        check("stream_popped", popped, 100);
        check("stream_model_drained", exp_q.size(), 0);

        // 5: reset mid-stream discards contents
        wr_sync();
        for (int i = 0; i < 8; i++) wr_cycle(1'b1, DW'(16'h0100 + i));
        apply_reset();
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_wr_level", wr_water_level, 0);
        check("midrst_rd_level", rd_water_level, 0);
        check("midrst_rd_addr", ram_rd_addr, 0);

        // 6: single push into empty FIFO (also checks write lands at address 0)
        wr_cycle(1'b1, 16'hbeef);
        n = 0;
        while (empty && n < 8) begin
            rd_sync();
            n++;
        end
        check("single_empty_released", empty, 0);
        check("single_latency_le4", n <= 4, 1);
        check("single_rd_level", rd_water_level, 1);
        check("single_head", rd_data, 16'hbeef);
        rd_cycle(1'b1);
        check("single_drained_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
